// File: rtl/aplic_imsic_pkg.sv
// Shared types for the APLIC -> IMSIC MSI dispatch fabric.
// Entry field widths match the default hart/file/EIID geometry.
package aplic_imsic_pkg;

  localparam logic [31:0] IMSIC_BASE_DEF = 32'h2400_0000;

  localparam int unsigned HART_W = 2;
  localparam int unsigned FILE_W = 2;
  localparam int unsigned EIID_W = 5;

  typedef struct packed {
    logic [HART_W-1:0] hart;
    logic [FILE_W-1:0] file;
    logic [EIID_W-1:0] eiid;
  } msi_entry_t;

  typedef enum logic [1:0] {
    DROP_NONE    = 2'd0,
    DROP_DECODE  = 2'd1,
    DROP_EIID    = 2'd2,
    DROP_TIMEOUT = 2'd3
  } drop_cause_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } dispatch_state_e;

endpackage

// File: rtl/aplic_imsic_msi_fifo.sv
// Circular FIFO of decoded MSI entries.
// Push is refused when full, pop is refused when empty.
module aplic_imsic_msi_fifo
  import aplic_imsic_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  msi_entry_t               i_din,
  output msi_entry_t               o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  msi_entry_t     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign o_full  = o_count == FULL_CNT;
  assign o_empty = o_count == '0;
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;
  assign o_dout  = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop) begin
        o_count <= o_count + (AW+1)'(1);
      end else if (!do_push && do_pop) begin
        o_count <= o_count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/aplic_imsic_msi_dispatch.sv
// Buffered MSI fabric: decodes APLIC MSI writes, queues them and
// delivers each to its target IMSIC with a per-entry timeout.
module aplic_imsic_msi_dispatch
  import aplic_imsic_pkg::*;
#(
  parameter int unsigned NR_HARTS      = 4,
  parameter int unsigned NR_INTP_FILES = 3,
  parameter int unsigned NR_SRC        = 32,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter logic [31:0] IMSIC_BASE    = IMSIC_BASE_DEF,
  parameter int unsigned FILE_SHIFT    = 12,
  parameter int unsigned HART_SHIFT    = 14,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_msi_valid,
  output logic                             o_msi_ready,
  input  logic [31:0]                      i_msi_addr,
  input  logic [31:0]                      i_msi_data,
  output logic [NR_HARTS-1:0]              o_imsic_valid,
  input  logic [NR_HARTS-1:0]              i_imsic_ready,
  output logic [$clog2(NR_INTP_FILES)-1:0] o_imsic_file,
  output logic [$clog2(NR_SRC)-1:0]        o_imsic_eiid,
  output logic                             o_drop_pulse,
  output logic [1:0]                       o_drop_cause,
  output logic [15:0]                      o_drop_cnt,
  output logic                             o_busy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [31:0] FMASK =
    (32'd1 << (HART_SHIFT - FILE_SHIFT)) - 32'd1;
  localparam logic [31:0] LMASK =
    (32'd1 << FILE_SHIFT) - 32'd1;
  localparam logic [WW-1:0] TMO_MAX = WW'(TIMEOUT);

  logic [31:0]     off;
  logic [31:0]     hart_fld;
  logic [31:0]     file_fld;
  logic            dec_err;
  logic            eiid_err;
  drop_cause_e     in_cause;
  msi_entry_t      ent;
  msi_entry_t      head;
  logic            accept;
  logic            push;
  logic            drop_in;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  dispatch_state_e state_q;
  dispatch_state_e state_d;
  logic [WW-1:0]   wait_q;
  logic            send;
  logic            tgt_ready;
  logic            hs;
  logic            tmo;
  logic            pop;
  drop_cause_e     cause_q;
  logic [16:0]     cnt_sum;

  // Whole field above HART_SHIFT is compared, so stray upper bits fail too
  always_comb begin
    off      = i_msi_addr - IMSIC_BASE;
    hart_fld = off >> HART_SHIFT;
    file_fld = (off >> FILE_SHIFT) & FMASK;
    dec_err  = (i_msi_addr < IMSIC_BASE)
            || (hart_fld >= NR_HARTS)
            || (file_fld >= NR_INTP_FILES)
            || ((off & LMASK) != '0);
    eiid_err = (i_msi_data == '0) || (i_msi_data >= NR_SRC);
    in_cause = dec_err ? DROP_DECODE : DROP_EIID;
    ent.hart = hart_fld[HART_W-1:0];
    ent.file = file_fld[FILE_W-1:0];
    ent.eiid = i_msi_data[EIID_W-1:0];
  end

  assign o_msi_ready = ~full;
  assign accept      = i_msi_valid & o_msi_ready;
  assign push        = accept & ~dec_err & ~eiid_err;
  assign drop_in     = accept & (dec_err | eiid_err);

  aplic_imsic_msi_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_pop   (pop),
    .i_din   (ent),
    .o_dout  (head),
    .o_full  (full),
    .o_empty (empty),
    .o_count (count)
  );

  assign send      = state_q == ST_SEND;
  assign tgt_ready = i_imsic_ready[head.hart];
  assign hs        = send & tgt_ready;
  assign tmo       = send & ~tgt_ready & (TIMEOUT != 0)
                   & (wait_q == TMO_MAX);
  assign pop       = hs | tmo;
  assign o_busy    = ~empty | send;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (!empty || push) state_d = ST_SEND;
      ST_SEND: begin
        if (pop && !push && count == CW'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_imsic_valid = '0;
    o_imsic_file  = '0;
    o_imsic_eiid  = '0;
    if (send) begin
      o_imsic_valid[head.hart] = 1'b1;
      o_imsic_file = head.file;
      o_imsic_eiid = head.eiid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      if (!send || pop) begin
        wait_q <= '0;
      end else if (wait_q != TMO_MAX) begin
        wait_q <= wait_q + WW'(1);
      end
    end
  end

  // Ingress and timeout drops can coincide; the timeout wins the cause
  assign cnt_sum = {1'b0, o_drop_cnt} + 17'(drop_in) + 17'(tmo);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_drop_pulse <= 1'b0;
      cause_q      <= DROP_NONE;
      o_drop_cnt   <= '0;
    end else begin
      o_drop_pulse <= drop_in | tmo;
      if (tmo) begin
        cause_q <= DROP_TIMEOUT;
      end else if (drop_in) begin
        cause_q <= in_cause;
      end
      o_drop_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

  assign o_drop_cause = cause_q;

endmodule
